// File: rtl/btb_if.sv
// Fetch-side lookup and execute-side training bundle for the branch target buffer.
interface btb_if #(
  parameter int N_ENTRIES  = 8,
  parameter int ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0]          lk_pc;
  logic                           lk_hit;
  logic                           lk_taken;
  logic [ADDR_WIDTH-1:0]          lk_target;
  logic                           upd_valid;
  logic [ADDR_WIDTH-1:0]          upd_pc;
  logic                           upd_taken;
  logic [ADDR_WIDTH-1:0]          upd_target;
  logic                           flush;
  logic [$clog2(N_ENTRIES):0]     occupancy;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
    input  lk_hit, lk_taken, lk_target, occupancy
  );
  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
    output lk_hit, lk_taken, lk_target, occupancy
  );
endinterface

// File: rtl/btb_2bc.sv
// Fully-associative BTB with 2-bit direction counters: combinational lookup,
// clocked training with invalid-first allocation and round-robin replacement.
module btb_2bc #(
  parameter int         N_ENTRIES  = 8,
  parameter int         ADDR_WIDTH = 24,
  parameter logic [1:0] CNT_INIT   = 2'b10
) (
  input  logic  clk,
  input  logic  reset,
  btb_if.slave  bus
);
  localparam int IW = $clog2(N_ENTRIES);
  localparam int OW = IW + 1;

  logic [N_ENTRIES-1:0]                 valid;
  logic [N_ENTRIES-1:0][ADDR_WIDTH-1:0] tag;
  logic [N_ENTRIES-1:0][ADDR_WIDTH-1:0] tgt;
  logic [N_ENTRIES-1:0][1:0]            cnt;
  logic [IW-1:0]                        ptr;
  logic [OW-1:0]                        occ;

  logic [N_ENTRIES-1:0] lk_match, upd_match;
  logic                 upd_hit, has_free;
  logic [IW-1:0]        upd_idx, free_idx, alloc_idx;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_match
    assign lk_match[g]  = valid[g] && (tag[g] == bus.lk_pc);
    assign upd_match[g] = valid[g] && (tag[g] == bus.upd_pc);
  end

  // Tags are unique among valid entries, so at most one lk_match bit is set.
  always_comb begin
    bus.lk_hit    = 1'b0;
    bus.lk_taken  = 1'b0;
    bus.lk_target = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (lk_match[i]) begin
        bus.lk_hit    = 1'b1;
        bus.lk_taken  = cnt[i][1];
        bus.lk_target = tgt[i];
      end
    end
  end

  // Descending scan so the lowest matching / invalid index wins.
  always_comb begin
    upd_hit  = 1'b0;
    upd_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
      if (upd_match[i]) begin
        upd_hit = 1'b1;
        upd_idx = IW'(i);
      end
    end
  end

  assign alloc_idx     = has_free ? free_idx : ptr;
  assign bus.occupancy = occ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      tag   <= '0;
      tgt   <= '0;
      cnt   <= {N_ENTRIES{2'b01}};
      ptr   <= '0;
      occ   <= '0;
    end else if (bus.flush) begin
      valid <= '0;
      ptr   <= '0;
      occ   <= '0;
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        if (bus.upd_taken) begin
          if (cnt[upd_idx] != 2'b11) cnt[upd_idx] <= cnt[upd_idx] + 2'b01;
          tgt[upd_idx] <= bus.upd_target;
        end else if (cnt[upd_idx] != 2'b00) begin
          cnt[upd_idx] <= cnt[upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        valid[alloc_idx] <= 1'b1;
        tag[alloc_idx]   <= bus.upd_pc;
        tgt[alloc_idx]   <= bus.upd_target;
        cnt[alloc_idx]   <= CNT_INIT;
        // A free slot means occ < N_ENTRIES, so the increment cannot overflow.
        if (has_free) occ <= occ + OW'(1);
        else          ptr <= ptr + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_btb_2bc.sv
// Directed bench for btb_2bc: reset, counter training, fill/replace, flush, same-cycle and async reset.
module tb_btb_2bc;
  localparam int AW = 24;
  localparam int NE = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   passed = 0;

  btb_if #(.N_ENTRIES(NE), .ADDR_WIDTH(AW)) bus ();
  btb_2bc #(.N_ENTRIES(NE), .ADDR_WIDTH(AW), .CNT_INIT(2'b10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Called right after a negedge: present pc, let comb settle.
  task automatic look(input logic [AW-1:0] pc);
    bus.lk_pc = pc;
    #1;
  endtask

  // Holds one training request across exactly one posedge.
  task automatic upd(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tg;
    @(negedge clk);
    bus.upd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    bus.lk_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
    bus.upd_taken = 1'b0; bus.upd_target = '0; bus.flush = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    upd(24'h000000, 1'b1, 24'h000123);
    look(24'h000000);
    total++;
    if ({bus.lk_hit, bus.lk_taken, bus.lk_target} !== {1'b0, 1'b0, 24'h0})
      $display("FAIL reset_lookup: got hit=%b tk=%b tgt=%h want 0 0 000000", bus.lk_hit, bus.lk_taken, bus.lk_target);
    else passed++;
    total++;
    if (bus.occupancy !== 4'd0) $display("FAIL reset_occ: got %0d want 0", bus.occupancy);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    look(24'h000000);
    total++;
    if (bus.lk_hit !== 1'b0) $display("FAIL reset_tag0_alias: got hit=%b want 0", bus.lk_hit);
    else passed++;
  endtask

  task automatic test_alloc;
    @(negedge clk);
    upd(24'h000100, 1'b1, 24'h000200);
    look(24'h000100);
    total++;
    if ({bus.lk_hit, bus.lk_taken, bus.lk_target} !== {1'b1, 1'b1, 24'h200})
      $display("FAIL alloc_lookup: got hit=%b tk=%b tgt=%h want 1 1 000200", bus.lk_hit, bus.lk_taken, bus.lk_target);
    else passed++;
    total++;
    if (bus.occupancy !== 4'd1) $display("FAIL alloc_occ: got %0d want 1", bus.occupancy);
    else passed++;
  endtask

  task automatic test_counter;
    @(negedge clk);
    upd(24'h000100, 1'b0, 24'h000BAD);        // 10 -> 01
    look(24'h000100);
    total++;
    if ({bus.lk_hit, bus.lk_taken, bus.lk_target} !== {1'b1, 1'b0, 24'h200})
      $display("FAIL cnt_nt1: got hit=%b tk=%b tgt=%h want 1 0 000200", bus.lk_hit, bus.lk_taken, bus.lk_target);
    else passed++;
    @(negedge clk);
    upd(24'h000100, 1'b0, 24'h000BAD);        // 01 -> 00
    upd(24'h000100, 1'b0, 24'h000BAD);        // stays 00
    upd(24'h000100, 1'b1, 24'h000250);        // 00 -> 01, new target
    look(24'h000100);
    total++;
    if ({bus.lk_hit, bus.lk_taken, bus.lk_target} !== {1'b1, 1'b0, 24'h250})
      $display("FAIL cnt_floor: got hit=%b tk=%b tgt=%h want 1 0 000250", bus.lk_hit, bus.lk_taken, bus.lk_target);
    else passed++;
    @(negedge clk);
    upd(24'h000100, 1'b1, 24'h000250);        // 10
    upd(24'h000100, 1'b1, 24'h000250);        // 11
    upd(24'h000100, 1'b1, 24'h000260);        // stays 11
    look(24'h000100);
    total++;
    if ({bus.lk_taken, bus.lk_target} !== {1'b1, 24'h260})
      $display("FAIL cnt_sat_taken: got tk=%b tgt=%h want 1 000260", bus.lk_taken, bus.lk_target);
    else passed++;
    @(negedge clk);
    upd(24'h000100, 1'b0, 24'h000BAD);        // 11 -> 10, still taken
    look(24'h000100);
    total++;
    if (bus.lk_taken !== 1'b1) $display("FAIL cnt_ceiling: got tk=%b want 1", bus.lk_taken);
    else passed++;
    @(negedge clk);
    upd(24'h000700, 1'b0, 24'h000777);        // miss, not taken: ignored
    look(24'h000700);
    total++;
    if ({bus.lk_hit, bus.occupancy} !== {1'b0, 4'd1})
      $display("FAIL miss_nt_ignored: got hit=%b occ=%0d want 0 1", bus.lk_hit, bus.occupancy);
    else passed++;
  endtask

  task automatic test_replace;
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) upd(AW'(i * 16), 1'b1, AW'(32'h1000 + i));
    look(24'h000080);
    total++;
    if ({bus.lk_hit, bus.lk_target, bus.occupancy} !== {1'b1, 24'h001008, 4'd8})
      $display("FAIL fill_full: got hit=%b tgt=%h occ=%0d want 1 001008 8", bus.lk_hit, bus.lk_target, bus.occupancy);
    else passed++;
    @(negedge clk);
    upd(24'h000090, 1'b1, 24'h001009);
    look(24'h000010);
    total++;
    if (bus.lk_hit !== 1'b0) $display("FAIL victim0_evicted: got hit=%b want 0", bus.lk_hit);
    else passed++;
    look(24'h000090);
    total++;
    if ({bus.lk_hit, bus.lk_target} !== {1'b1, 24'h001009})
      $display("FAIL victim0_new: got hit=%b tgt=%h want 1 001009", bus.lk_hit, bus.lk_target);
    else passed++;
    @(negedge clk);
    upd(24'h0000A0, 1'b1, 24'h00100A);
    look(24'h000020);
    total++;
    if (bus.lk_hit !== 1'b0) $display("FAIL victim1_evicted: got hit=%b want 0", bus.lk_hit);
    else passed++;
    look(24'h000030);
    total++;
    if ({bus.lk_hit, bus.lk_target, bus.occupancy} !== {1'b1, 24'h001003, 4'd8})
      $display("FAIL replace_keep: got hit=%b tgt=%h occ=%0d want 1 001003 8", bus.lk_hit, bus.lk_target, bus.occupancy);
    else passed++;
  endtask

  task automatic test_flush;
    @(negedge clk);
    bus.flush = 1'b1;
    upd(24'h000300, 1'b1, 24'h000333);
    bus.flush = 1'b0;
    look(24'h000300);
    total++;
    if (bus.lk_hit !== 1'b0) $display("FAIL flush_upd_dropped: got hit=%b want 0", bus.lk_hit);
    else passed++;
    look(24'h000090);
    total++;
    if ({bus.lk_hit, bus.lk_target, bus.occupancy} !== {1'b0, 24'h0, 4'd0})
      $display("FAIL flush_clear: got hit=%b tgt=%h occ=%0d want 0 000000 0", bus.lk_hit, bus.lk_target, bus.occupancy);
    else passed++;
    // Refill, then one more allocation must evict entry0 if the pointer was reset.
    @(negedge clk);
    for (int i = 0; i < 8; i++) upd(AW'(32'h500 + i * 16), 1'b1, AW'(32'h2000 + i));
    upd(24'h000580, 1'b1, 24'h002008);
    look(24'h000500);
    total++;
    if (bus.lk_hit !== 1'b0) $display("FAIL flush_ptr_entry0: got hit=%b want 0", bus.lk_hit);
    else passed++;
    look(24'h000520);
    total++;
    if ({bus.lk_hit, bus.occupancy} !== {1'b1, 4'd8})
      $display("FAIL flush_ptr_others: got hit=%b occ=%0d want 1 8", bus.lk_hit, bus.occupancy);
    else passed++;
  endtask

  task automatic test_same_cycle_and_async;
    @(negedge clk);
    bus.lk_pc      = 24'h000400;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 24'h000400;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 24'h000404;
    #1;
    total++;
    if (bus.lk_hit !== 1'b0) $display("FAIL same_cycle_nobypass: got hit=%b want 0", bus.lk_hit);
    else passed++;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    #1;
    total++;
    if ({bus.lk_hit, bus.lk_target} !== {1'b1, 24'h000404})
      $display("FAIL same_cycle_next: got hit=%b tgt=%h want 1 000404", bus.lk_hit, bus.lk_target);
    else passed++;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.lk_hit, bus.lk_target, bus.occupancy} !== {1'b0, 24'h0, 4'd0})
      $display("FAIL async_reset: got hit=%b tgt=%h occ=%0d want 0 000000 0", bus.lk_hit, bus.lk_target, bus.occupancy);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    look(24'h000400);
    total++;
    if (bus.lk_hit !== 1'b0) $display("FAIL post_reset_miss: got hit=%b want 0", bus.lk_hit);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_replace();
    test_flush();
    test_same_cycle_and_async();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
